// File: rtl/cache_axi_master_bridge_pkg.sv
// rtl/cache_axi_master_bridge_pkg.sv - state encodings and AXI constants shared by the cache AXI bridge
package cache_axi_master_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_B    = 2'd3
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // AXI size codes: bytes per beat
    localparam logic [2:0] AXI_SIZE_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_4 = 3'd2;

endpackage

// File: rtl/cache_bridge_size_enc.sv
// rtl/cache_bridge_size_enc.sv - maps cache byte select and beat count onto an AXI transfer size
module cache_bridge_size_enc
    import cache_axi_master_bridge_pkg::*;
(
    input  logic [3:0] sel_i,
    input  logic [3:0] len_i,
    output logic [2:0] size_o
);

    // Bursts are always full words; single beats take their width from the byte select
    always_comb begin
        size_o = AXI_SIZE_4;
        if (len_i == 4'd0) begin
            case (sel_i)
                4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = AXI_SIZE_1;
                4'b0011, 4'b1100:                   size_o = AXI_SIZE_2;
                default:                            size_o = AXI_SIZE_4;
            endcase
        end
    end

endmodule

// File: rtl/cache_axi_master_bridge.sv
// rtl/cache_axi_master_bridge.sv - cache request port to AXI3 master bridge; CACHE_BRIDGE_EARLY_WRESP_EN acks the last write beat on wlast
module cache_axi_master_bridge
    import cache_axi_master_bridge_pkg::*;
#(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        c_ren_i,
    input  logic [31:0] c_raddr_i,
    input  logic [3:0]  c_rlen_i,
    input  logic [3:0]  c_rsel_i,
    input  logic        c_rready_i,
    output logic [31:0] c_rdata_o,
    output logic        c_rvalid_o,
    input  logic        c_wen_i,
    input  logic [31:0] c_waddr_i,
    input  logic [31:0] c_wdata_i,
    input  logic [3:0]  c_wsel_i,
    input  logic [3:0]  c_wlen_i,
    output logic        c_wresp_o,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awvalid,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e   rd_state_q, rd_state_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [2:0]  rd_size;

    wr_state_e   wr_state_q, wr_state_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [3:0]  awlen_q, awlen_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  wbeat_q, wbeat_d;
    logic [2:0]  wr_size;

    logic        r_fire;
    logic        w_fire;
    logic        w_last_beat;
    logic        b_fire;

    // Response IDs and status are not needed: one outstanding transaction per direction
    logic        unused_axi_rsp;
    assign unused_axi_rsp = ^{rid, rresp, bid, bresp};

    cache_bridge_size_enc u_rd_size (
        .sel_i  (c_rsel_i),
        .len_i  (c_rlen_i),
        .size_o (rd_size)
    );

    cache_bridge_size_enc u_wr_size (
        .sel_i  (c_wsel_i),
        .len_i  (c_wlen_i),
        .size_o (wr_size)
    );

    // Read engine: latch request, present AR, then stream R beats back to the initiator
    always_comb begin
        rd_state_d = rd_state_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        case (rd_state_q)
            R_IDLE: begin
                if (c_ren_i) begin
                    araddr_d   = c_raddr_i;
                    arlen_d    = c_rlen_i;
                    arsize_d   = rd_size;
                    arvalid_d  = 1'b1;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                if (arvalid_q && arready) begin
                    arvalid_d  = 1'b0;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_fire && rlast) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read engine state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= 32'd0;
            arlen_q    <= 4'd0;
            arsize_q   <= 3'd0;
        end else begin
            rd_state_q <= rd_state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
        end
    end

    assign rready     = (rd_state_q == R_DATA) && c_rready_i;
    assign r_fire     = rvalid && rready;
    assign c_rvalid_o = r_fire;
    assign c_rdata_o  = rdata;

    assign arid    = RD_ID;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign w_fire      = wvalid_q && wready;
    assign w_last_beat = (wbeat_q == awlen_q[2:0]);
    assign b_fire      = bready_q && bvalid;

    // Write engine: AW first, then W beats fed straight from the initiator, then wait for B
    always_comb begin
        wr_state_d = wr_state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        awaddr_d   = awaddr_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        wstrb_d    = wstrb_q;
        wbeat_d    = wbeat_q;
        case (wr_state_q)
            W_IDLE: begin
                if (c_wen_i) begin
                    awaddr_d   = c_waddr_i;
                    awlen_d    = c_wlen_i;
                    awsize_d   = wr_size;
                    wstrb_d    = (c_wlen_i == 4'd0) ? c_wsel_i : 4'hF;
                    wbeat_d    = 3'd0;
                    awvalid_d  = 1'b1;
                    wr_state_d = W_AW;
                end
            end
            W_AW: begin
                if (awvalid_q && awready) begin
                    awvalid_d  = 1'b0;
                    wvalid_d   = 1'b1;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_fire) begin
                    if (w_last_beat) begin
                        wvalid_d   = 1'b0;
                        bready_d   = 1'b1;
                        wbeat_d    = 3'd0;
                        wr_state_d = W_B;
                    end else begin
                        wbeat_d = wbeat_q + 3'd1;
                    end
                end
            end
            W_B: begin
                if (b_fire) begin
                    bready_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write engine state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_state_q <= W_IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            awaddr_q   <= 32'd0;
            awlen_q    <= 4'd0;
            awsize_q   <= 3'd0;
            wstrb_q    <= 4'd0;
            wbeat_q    <= 3'd0;
        end else begin
            wr_state_q <= wr_state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            awaddr_q   <= awaddr_d;
            awlen_q    <= awlen_d;
            awsize_q   <= awsize_d;
            wstrb_q    <= wstrb_d;
            wbeat_q    <= wbeat_d;
        end
    end

`ifdef CACHE_BRIDGE_EARLY_WRESP_EN
    // Every beat, including the last, is acknowledged on its W handshake
    assign c_wresp_o = w_fire;
`else
    // The last beat is acknowledged only once B returns
    assign c_wresp_o = (w_fire && !w_last_beat) || b_fire;
`endif

    assign awid    = WR_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_q;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign wid    = WR_ID;
    assign wdata  = c_wdata_i;
    assign wstrb  = wstrb_q;
    assign wlast  = wvalid_q && w_last_beat;
    assign wvalid = wvalid_q;
    assign bready = bready_q;

endmodule

// File: tb/tb_cache_axi_master_bridge.sv
// tb/tb_cache_axi_master_bridge.sv - self-checking bench for cache_axi_master_bridge
`timescale 1ns/1ps
module tb_cache_axi_master_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        c_ren_i, c_rready_i, c_rvalid_o, c_wen_i, c_wresp_o;
    logic [31:0] c_raddr_i, c_rdata_o, c_waddr_i, c_wdata_i;
    logic [3:0]  c_rlen_i, c_rsel_i, c_wsel_i, c_wlen_i;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    cache_axi_master_bridge dut (
        .clk(clk), .resetn(resetn),
        .c_ren_i(c_ren_i), .c_raddr_i(c_raddr_i), .c_rlen_i(c_rlen_i), .c_rsel_i(c_rsel_i),
        .c_rready_i(c_rready_i), .c_rdata_o(c_rdata_o), .c_rvalid_o(c_rvalid_o),
        .c_wen_i(c_wen_i), .c_waddr_i(c_waddr_i), .c_wdata_i(c_wdata_i), .c_wsel_i(c_wsel_i),
        .c_wlen_i(c_wlen_i), .c_wresp_o(c_wresp_o),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents the AXI slave returns for a word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h0101};
    endfunction

    // Expected transaction, set by the stimulus before each request
    logic [31:0] exp_ar_addr, exp_aw_addr;
    logic [3:0]  exp_ar_len, exp_aw_len, exp_strb;
    logic [2:0]  exp_ar_size, exp_aw_size;
    logic [31:0] wtab [8];

    // AXI slave configuration
    int ar_delay, aw_delay;
    bit w_toggle;

    // AXI slave: AR after a programmable wait, back-to-back R beats, W with optional stalls, B two cycles after wlast
    initial begin : axi_slave
        int ar_wait, aw_wait, r_left, b_cnt;
        logic [31:0] r_addr, s_araddr;
        logic [3:0]  s_arlen;
        bit f_ar, f_r, f_aw, f_wl, f_b;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 4'd0; rresp = 2'b00;
        awready = 0; wready = 0; bvalid = 0; bid = 4'd1; bresp = 2'b00;
        ar_wait = 0; aw_wait = 0; r_left = 0; b_cnt = 0; r_addr = 0;
        forever begin
            @(negedge clk);
            f_ar = arvalid && arready;
            f_r  = rvalid && rready;
            f_aw = awvalid && awready;
            f_wl = wvalid && wready && wlast;
            f_b  = bvalid && bready;
            s_araddr = araddr;
            s_arlen  = arlen;
            @(posedge clk);
            #1;
            if (!resetn) begin
                arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
                ar_wait = 0; aw_wait = 0; r_left = 0; b_cnt = 0;
            end else begin
                if (f_ar) begin
                    arready = 0; ar_wait = 0; r_addr = s_araddr; r_left = int'(s_arlen) + 1;
                end else if (arvalid) begin
                    if (ar_wait >= ar_delay) arready = 1; else ar_wait++;
                end
                if (f_r) begin
                    r_left--; r_addr = r_addr + 32'd4;
                end
                if (r_left > 0) begin
                    rvalid = 1; rdata = mem_word(r_addr); rlast = (r_left == 1);
                end else begin
                    rvalid = 0; rlast = 0;
                end
                if (f_aw) begin
                    awready = 0; aw_wait = 0;
                end else if (awvalid) begin
                    if (aw_wait >= aw_delay) awready = 1; else aw_wait++;
                end
                wready = w_toggle ? ~wready : 1'b1;
                if (f_b) bvalid = 0;
                if (f_wl) b_cnt = 2;
                else if (b_cnt > 0) begin
                    b_cnt--;
                    if (b_cnt == 0) bvalid = 1;
                end
            end
        end
    end

    // Compare process: every cycle, check AXI requests, returned read data, W beats and ack placement
    initial begin : compare
        int m_rbeat, m_wbeat, m_wresp;
        bit m_aw_done, final_ok;
        m_rbeat = 0; m_wbeat = 0; m_wresp = 0; m_aw_done = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                m_rbeat = 0; m_wbeat = 0; m_wresp = 0; m_aw_done = 0;
            end else begin
                if (arvalid) begin
                    check("araddr", araddr, exp_ar_addr);
                    check("arlen", 32'(arlen), 32'(exp_ar_len));
                    check("arsize", 32'(arsize), 32'(exp_ar_size));
                    check("arburst", 32'(arburst), 32'd1);
                    check("arid", 32'(arid), 32'd0);
                    check("ar_tied", 32'({arlock, arcache, arprot}), 32'd0);
                end
                if (arvalid && arready) m_rbeat = 0;
                if (c_rvalid_o) begin
                    check("c_rvalid_qual", 32'(rvalid && c_rready_i), 32'd1);
                    check("rd_beat_range", 32'(m_rbeat <= int'(exp_ar_len)), 32'd1);
                    check("c_rdata", c_rdata_o, mem_word(exp_ar_addr + 32'(4 * m_rbeat)));
                    m_rbeat++;
                end
                if (awvalid) begin
                    check("awaddr", awaddr, exp_aw_addr);
                    check("awlen", 32'(awlen), 32'(exp_aw_len));
                    check("awsize", 32'(awsize), 32'(exp_aw_size));
                    check("awburst", 32'(awburst), 32'd1);
                    check("awid", 32'(awid), 32'd1);
                    check("aw_tied", 32'({awlock, awcache, awprot}), 32'd0);
                end
                if (wvalid) check("w_after_aw", 32'(m_aw_done), 32'd1);
                if (awvalid && awready) begin
                    m_aw_done = 1; m_wbeat = 0; m_wresp = 0;
                end
                if (wvalid && wready) begin
                    check("wdata", wdata, wtab[m_wbeat & 7]);
                    check("wstrb", 32'(wstrb), 32'(exp_strb));
                    check("wid", 32'(wid), 32'd1);
                    check("wlast", 32'(wlast), 32'(m_wbeat == int'(exp_aw_len)));
                    m_wbeat++;
                end
                if (c_wresp_o) begin
                    m_wresp++;
                    if (m_wresp == int'(exp_aw_len) + 1) begin
`ifdef CACHE_BRIDGE_EARLY_WRESP_EN
                        final_ok = wvalid && wready && wlast;
`else
                        final_ok = bvalid && bready;
`endif
                        check("wresp_final_pos", 32'(final_ok), 32'd1);
                    end else begin
                        check("wresp_beat_pos", 32'(wvalid && wready && !wlast && m_wresp <= int'(exp_aw_len)), 32'd1);
                    end
                end
                if (bvalid && bready) m_aw_done = 0;
            end
        end
    end

    // Read initiator: hold c_ren_i until the last beat (or until nbeats beats when stopping early)
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] sel,
                           input logic [2:0] esize, input bit rr_toggle, input int nbeats);
        int got, cyc;
        bit fire;
        got = 0; cyc = 0;
        exp_ar_addr = addr; exp_ar_len = len; exp_ar_size = esize;
        c_raddr_i = addr; c_rlen_i = len; c_rsel_i = sel; c_ren_i = 1;
        while (got < nbeats && cyc < 300) begin
            @(negedge clk);
            fire = c_rvalid_o;
            @(posedge clk);
            #1;
            cyc++;
            if (fire) got++;
            if (rr_toggle) c_rready_i = ~c_rready_i;
        end
        if (got == int'(len) + 1) c_ren_i = 0;
        c_rready_i = 1;
        check("rd_beat_count", 32'(got), 32'(nbeats));
    endtask

    // Write initiator: advance c_wdata_i on each ack, hold c_wen_i until the final ack
    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] sel,
                            input logic [2:0] esize, input logic [3:0] estrb, input logic [31:0] seed);
        int got, cyc;
        bit fire;
        got = 0; cyc = 0;
        for (int i = 0; i < 8; i++) wtab[i] = seed + 32'(i) * 32'h0101_0101;
        exp_aw_addr = addr; exp_aw_len = len; exp_aw_size = esize; exp_strb = estrb;
        c_waddr_i = addr; c_wlen_i = len; c_wsel_i = sel; c_wdata_i = wtab[0]; c_wen_i = 1;
        while (got < int'(len) + 1 && cyc < 300) begin
            @(negedge clk);
            fire = c_wresp_o;
            @(posedge clk);
            #1;
            cyc++;
            if (fire) begin
                got++;
                if (got < 8) c_wdata_i = wtab[got];
            end
        end
        c_wen_i = 0;
        check("wr_resp_count", 32'(got), 32'(len) + 32'd1);
    endtask

    initial begin : stimulus
        resetn = 0;
        c_ren_i = 0; c_raddr_i = 0; c_rlen_i = 0; c_rsel_i = 0; c_rready_i = 1;
        c_wen_i = 0; c_waddr_i = 0; c_wdata_i = 0; c_wsel_i = 0; c_wlen_i = 0;
        exp_ar_addr = 0; exp_ar_len = 0; exp_ar_size = 0;
        exp_aw_addr = 0; exp_aw_len = 0; exp_aw_size = 0; exp_strb = 0;
        for (int i = 0; i < 8; i++) wtab[i] = 0;
        ar_delay = 0; aw_delay = 0; w_toggle = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_wlast", 32'(wlast), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_c_rvalid", 32'(c_rvalid_o), 32'd0);
        check("rst_c_wresp", 32'(c_wresp_o), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_arlen_size", 32'({arlen, arsize}), 32'd0);
        resetn = 1;
        @(posedge clk);
        #1;

        // Cached line read with a slow arready
        ar_delay = 3;
        do_read(32'h1FC0_0020, 4'd7, 4'hF, 3'd2, 1'b0, 8);
        repeat (2) @(posedge clk);
        #1;
        check("rd_idle_arvalid", 32'(arvalid), 32'd0);
        check("rd_idle_rready", 32'(rready), 32'd0);
        ar_delay = 0;

        // Uncached byte read
        do_read(32'hBFAF_8002, 4'd0, 4'b0100, 3'd0, 1'b0, 1);
        repeat (2) @(posedge clk);
        #1;

        // Cached write with wready toggling
        w_toggle = 1;
        aw_delay = 1;
        do_write(32'h0000_1000, 4'd7, 4'hF, 3'd2, 4'hF, 32'hC0DE_0000);
        w_toggle = 0;
        aw_delay = 0;
        repeat (5) @(posedge clk);
        #1;

        // Uncached halfword write
        do_write(32'hA000_0012, 4'd0, 4'b1100, 3'd1, 4'b1100, 32'h1234_5678);
        repeat (5) @(posedge clk);
        #1;

        // Concurrent read and write requested in the same cycle
        fork
            do_read(32'h0000_2000, 4'd7, 4'hF, 3'd2, 1'b1, 8);
            do_write(32'h0000_3000, 4'd7, 4'hF, 3'd2, 4'hF, 32'hBEEF_0000);
            begin
                @(posedge clk);
                #2;
                check("ar_aw_together", 32'({arvalid, awvalid}), 32'd3);
            end
        join
        repeat (5) @(posedge clk);
        #1;

        // Asynchronous reset part-way through a read burst
        do_read(32'h0000_5000, 4'd7, 4'hF, 3'd2, 1'b0, 4);
        #2;
        resetn = 0;
        c_ren_i = 0;
        #1;
        check("arst_rready", 32'(rready), 32'd0);
        check("arst_c_rvalid", 32'(c_rvalid_o), 32'd0);
        check("arst_valids", 32'({arvalid, awvalid, wvalid, bready, c_wresp_o}), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        resetn = 1;
        @(posedge clk);
        #1;
        do_read(32'h0000_4040, 4'd7, 4'hF, 3'd2, 1'b0, 8);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
